// File: rtl/core_pkg.sv
// Shared fetch-pipeline definitions: canonical NOP encoding, fetch FSM states
// and the word-alignment helper used on every fetch address.
package core_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush; the head entry is visible combinationally so the
// consumer can decide to pop in the same cycle.
module fifo_sync #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   CLOCK,
  input  logic                   RST_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: keeps one memory request in flight and buffers
// fetched {pc, instruction} pairs for the core, with redirect-driven flushing.
module if_prefetch
  import core_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] PC,
  output logic        instr_valid
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   parked_pc;
  logic          discard;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic          acked;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [CW-1:0] occupancy_next;
  logic          space_next;

  assign acked          = (state == REQ) && imem_ack;
  assign push           = acked && !discard && !redirect;
  assign head_valid     = (count != '0) && !redirect;
  assign pop            = head_valid && !stall;
  assign occupancy_next = count + CW'(push) - CW'(pop);
  assign space_next     = occupancy_next < DEPTH_CNT;

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_next;
  end

  // A request is only launched while a FIFO slot is still free, so the ack can always push.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!redirect && space_next) state_next = REQ;
      REQ:     if (push && !space_next)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A redirect during an unacked request parks its target until that handshake retires.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      fetch_pc  <= RESET_PC;
      parked_pc <= '0;
      discard   <= 1'b0;
    end else if (redirect) begin
      if ((state == REQ) && !imem_ack) begin
        parked_pc <= word_align(redirect_pc);
        discard   <= 1'b1;
      end else begin
        fetch_pc  <= word_align(redirect_pc);
        discard   <= 1'b0;
      end
    end else if (acked) begin
      if (discard) begin
        fetch_pc <= parked_pc;
        discard  <= 1'b0;
      end else begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fifo_sync #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .CLOCK    (CLOCK),
    .RST_n    (RST_n),
    .push     (push),
    .push_data({fetch_pc, imem_rdata}),
    .pop      (pop),
    .flush    (redirect),
    .head_data(head),
    .count    (count)
  );

  assign imem_req    = (state == REQ);
  assign imem_addr   = fetch_pc;
  assign instr_valid = head_valid;
  assign instr       = head_valid ? head[31:0]  : NOP;
  assign PC          = head_valid ? head[63:32] : 32'h0;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_if_prefetch;
  import core_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLOCK = 1'b0;
  logic        RST_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] PC;
  logic        instr_valid;

  int checks   = 0;
  int failures = 0;
  int req_seen;

  logic [63:0] model_q[$];
  logic        model_active = 1'b0;
  logic        model_drop   = 1'b0;
  logic [31:0] model_addr   = RESET_PC;
  logic [31:0] model_parked = 32'h0;
  logic        model_valid;
  logic        exp_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_prefetch #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .CLOCK      (CLOCK),
    .RST_n      (RST_n),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .PC         (PC),
    .instr_valid(instr_valid)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic st, input logic ak);
    redirect    = rd;
    redirect_pc = rpc;
    stall       = st;
    imem_ack    = ak;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic doReset();
    RST_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    RST_n = 1'b1;
  endtask

  // Reference model: a queue of fetched pairs plus the single in-flight request.
  initial forever begin
    @(posedge CLOCK or negedge RST_n);
    if (!RST_n) begin
      model_q.delete();
      model_active = 1'b0;
      model_drop   = 1'b0;
      model_addr   = RESET_PC;
      model_parked = 32'h0;
    end else if (redirect) begin
      model_q.delete();
      if (model_active && !imem_ack) begin
        model_drop   = 1'b1;
        model_parked = {redirect_pc[31:2], 2'b00};
      end else begin
        model_drop = 1'b0;
        model_addr = {redirect_pc[31:2], 2'b00};
      end
    end else begin
      model_valid = model_q.size() > 0;
      if (model_valid && !stall) void'(model_q.pop_front());
      if (model_active && imem_ack) begin
        if (model_drop) begin
          model_drop = 1'b0;
          model_addr = model_parked;
        end else begin
          model_q.push_back({model_addr, mem_word(model_addr)});
          model_addr = model_addr + 32'd4;
        end
        model_active = model_q.size() < DEPTH;
      end else if (!model_active) begin
        model_active = model_q.size() < DEPTH;
      end
    end
  end

  initial forever begin
    @(negedge CLOCK);
    exp_valid = (model_q.size() > 0) && !redirect;
    checkOutput("imem_req", 32'(imem_req), 32'(model_active));
    checkOutput("imem_addr", imem_addr, model_addr);
    checkOutput("instr_valid", 32'(instr_valid), 32'(exp_valid));
    checkOutput("instr", instr, exp_valid ? model_q[0][31:0] : NOP);
    checkOutput("PC", PC, exp_valid ? model_q[0][63:32] : 32'h0);
  end

  initial begin
    RST_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    imem_ack    = 1'b0;
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_req", 32'(imem_req), 32'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_pc", PC, 32'h0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    nextCycle();
    RST_n = 1'b1;

    // Streaming with ack tied high
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stream_idle_req", 32'(imem_req), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stream_first_req", 32'(imem_req), 32'h1);
    checkOutput("stream_first_addr", imem_addr, 32'h0);
    checkOutput("stream_first_valid", 32'(instr_valid), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stream_addr4", imem_addr, 32'h4);
    checkOutput("stream_valid", 32'(instr_valid), 32'h1);
    checkOutput("stream_pc0", PC, 32'h0);
    checkOutput("stream_instr0", instr, 32'hC0DE_0001);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stream_addr8", imem_addr, 32'h8);
    checkOutput("stream_pc4", PC, 32'h4);
    nextCycle();
    nextCycle();

    // Stall held with FIFO filling
    doReset();
    req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      if (imem_req) req_seen++;
      nextCycle();
    end
    checkOutput("stall_req_count", 32'(req_seen), 32'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stall_full_req", 32'(imem_req), 32'h0);
    checkOutput("stall_full_pc", PC, 32'h0);
    checkOutput("stall_full_addr", imem_addr, 32'h10);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stall_resume_req", 32'(imem_req), 32'h1);
    checkOutput("stall_resume_addr", imem_addr, 32'h10);
    checkOutput("stall_resume_pc", PC, 32'h4);
    nextCycle();

    // Ack delayed three cycles
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, (i == 4));
      if (i > 0) begin
        checkOutput("delay_req", 32'(imem_req), 32'h1);
        checkOutput("delay_addr", imem_addr, 32'h0);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("delay_valid", 32'(instr_valid), 32'h1);
    checkOutput("delay_pc", PC, 32'h0);
    checkOutput("delay_next_addr", imem_addr, 32'h4);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("delay_pop_pc", PC, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("delay_single_push", 32'(instr_valid), 32'h0);
    nextCycle();

    // Redirect while a request is outstanding
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("redir_pre_addr", imem_addr, 32'h4);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0103, 1'b0, 1'b0);
    checkOutput("redir_valid", 32'(instr_valid), 32'h0);
    checkOutput("redir_instr", instr, 32'h0000_0013);
    checkOutput("redir_addr", imem_addr, 32'h8);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("redir_hold_req", 32'(imem_req), 32'h1);
    checkOutput("redir_hold_addr", imem_addr, 32'h8);
    checkOutput("redir_empty", 32'(instr_valid), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("redir_new_addr", imem_addr, 32'h100);
    checkOutput("redir_dropped", 32'(instr_valid), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("redir_pc", PC, 32'h100);
    checkOutput("redir_instr_new", instr, mem_word(32'h100));
    nextCycle();

    // Redirect coincident with ack
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    checkOutput("coinc_valid", 32'(instr_valid), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("coinc_req", 32'(imem_req), 32'h1);
    checkOutput("coinc_addr", imem_addr, 32'h200);
    checkOutput("coinc_empty", 32'(instr_valid), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("coinc_pc", PC, 32'h200);
    checkOutput("coinc_instr", instr, mem_word(32'h200));
    nextCycle();

    // Address wrap at the top of the space
    applyStimulus(1'b1, 32'hFFFF_FFF9, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_addr_fff8", imem_addr, 32'hFFFF_FFF8);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_pc_fff8", PC, 32'hFFFF_FFF8);
    checkOutput("wrap_addr_fffc", imem_addr, 32'hFFFF_FFFC);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_pc_fffc", PC, 32'hFFFF_FFFC);
    checkOutput("wrap_addr_0", imem_addr, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_pc_0", PC, 32'h0);
    nextCycle();

    // Reset pulsed in the middle of a request
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("midrst_pre_req", 32'(imem_req), 32'h1);
    RST_n = 1'b0;
    #1;
    checkOutput("midrst_req", 32'(imem_req), 32'h0);
    checkOutput("midrst_valid", 32'(instr_valid), 32'h0);
    checkOutput("midrst_instr", instr, 32'h0000_0013);
    checkOutput("midrst_pc", PC, 32'h0);
    checkOutput("midrst_addr", imem_addr, RESET_PC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    RST_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("restart_idle", 32'(imem_req), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("restart_req", 32'(imem_req), 32'h1);
    checkOutput("restart_addr", imem_addr, RESET_PC);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("restart_pc", PC, RESET_PC);
    checkOutput("restart_instr", instr, mem_word(RESET_PC));
    nextCycle();
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 CLOCK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_n  input  1  asynchronous, active-low reset.
REQ-005 redirect  input  1  taken branch/jump from the core; flushes the queue.
REQ-006 redirect_pc  input  32  new fetch address when redirect=1.
REQ-007 stall  input  1  core not accepting an instruction this cycle.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  word-aligned request address.
REQ-010 imem_ack  input  1  memory accepts request; imem_rdata valid the same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 instr  output  32  instruction at FIFO head.
REQ-013 PC  output  32  address of instr.
REQ-014 instr_valid  output  1  FIFO head valid.

Function
REQ-015 fetch_pc register holds the next address to request; imem_addr SHALL equal fetch_pc.
REQ-016 FSM states IDLE, REQ; imem_req=1 only in REQ.
REQ-017 IDLE->REQ when (count + popping-adjusted occupancy) < DEPTH and no redirect this cycle.
REQ-018 In REQ, imem_req and imem_addr held stable until imem_ack=1.
REQ-019 On imem_ack: push {fetch_pc, imem_rdata} unless discard flag set; fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000); stay in REQ if space remains after the push, else go to IDLE.
REQ-020 Single outstanding request; FIFO SHALL never overflow (push only when space reserved at issue).
REQ-021 Pop when instr_valid=1 and stall=0; push and pop in the same cycle keep count unchanged.
REQ-022 instr_valid=1 iff count>0 and no redirect this cycle; when invalid, instr=32'h0000_0013 (NOP) and PC=0.
REQ-023 Latency: ack at cycle N -> instr_valid at N+1 when FIFO was empty.
REQ-024 redirect=1: FIFO count->0 next cycle; fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-025 redirect in REQ without ack: req stays asserted on the old address until ack (handshake not aborted); discard flag set; that response dropped; then REQ issues redirect_pc.
REQ-026 redirect with imem_ack in the same cycle: response dropped, fetch_pc <= redirect_pc, discard not set; REQ re-issued next cycle.
REQ-027 redirect takes priority over push, pop and stall in the same cycle.
REQ-028 stall with FIFO full: FSM remains IDLE, no request issued.

Reset
REQ-029 On RST_n=0: state IDLE, fetch_pc=RESET_PC, count/pointers=0, discard=0, imem_req=0, instr_valid=0, instr=NOP, PC=0.
REQ-030 Reset asserted mid-request: imem_req drops asynchronously; any pending ack ignored after reset release.
REQ-031 First request issued the first cycle after RST_n deasserts.

Structure
REQ-032 Shared package core_pkg holds NOP constant (32'h0000_0013) and FSM state enum.
REQ-033 FIFO storage in one sub-module fifo_sync (parameter DEPTH, 64-bit entries, push/pop/flush, count).
REQ-034 No memory-array inference beyond fifo_sync; all outputs except instr/PC/instr_valid registered.

Verification
REQ-035 Reset release, imem_ack tied 1, stall=0 -> addresses 0x0,0x4,0x8... one per cycle; instr_valid from cycle 2 with PC matching.
REQ-036 stall=1 held, ack always 1, DEPTH=4 -> exactly 4 requests, imem_req=0 afterwards, PC stays 0x0; release stall -> requests resume at 0x10.
REQ-037 ack delayed 3 cycles -> imem_req/imem_addr stable for 4 cycles; single push on ack.
REQ-038 redirect to 0x103 while request to 0x8 pending -> 0x8 data dropped, next request to 0x100, FIFO empty one cycle after redirect.
REQ-039 redirect coincident with ack -> acked word never appears on instr; next addr = redirect_pc.
REQ-040 RST_n pulsed low mid-REQ -> imem_req=0 immediately, outputs at reset values, restart at RESET_PC.
